// File: rtl/gobou_serial_writer.sv
// -----------------------------------------------------------------------------
// gobou_serial_writer
//
// Purpose:
//   Sits after the gobou 16-lane parallel-to-serial vector stage. Each
//   i_serial_we pulse marks the start of a batch; over the next CORE cycles
//   the serializer presents one lane per cycle on i_serial_data. Every lane
//   that still belongs to the layer is optionally ReLU-clamped and written to
//   the output memory at consecutive addresses starting from the layer base.
//   Lanes of a final partial batch beyond the layer's output count are
//   dropped. Layer completion is reported to the controller with a one-cycle
//   o_done pulse.
//
// Ports:
//   i_clk          clock
//   i_rst          synchronous active-high reset
//   i_start        one-cycle pulse, begins a layer (ignored while busy)
//   i_base_addr    first write address of the layer
//   i_out_size     total outputs in the layer
//   i_relu_en      clamp negative words to zero when 1
//   i_serial_we    batch-start pulse (same pulse that loads the serializer)
//   i_serial_data  serializer output word, signed
//   o_mem_we       output memory write enable
//   o_mem_addr     output memory write address
//   o_mem_wdata    output memory write data
//   o_busy         high from accepted start until done
//   o_done         one-cycle pulse, layer complete
//   o_overrun      sticky, a batch restarted before the previous one finished
// -----------------------------------------------------------------------------
module gobou_serial_writer #(
    parameter int DWIDTH = 16,
    parameter int LWIDTH = 10,
    parameter int AWIDTH = 12,
    parameter int CORE   = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [AWIDTH-1:0] i_base_addr,
    input  logic [LWIDTH-1:0] i_out_size,
    input  logic              i_relu_en,
    input  logic              i_serial_we,
    input  logic [DWIDTH-1:0] i_serial_data,
    output logic              o_mem_we,
    output logic [AWIDTH-1:0] o_mem_addr,
    output logic [DWIDTH-1:0] o_mem_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overrun
);

    // Phase runs 1..CORE, so it needs room for the value CORE itself.
    localparam int PWIDTH = $clog2(CORE + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_STREAM,
        S_FIN
    } state_t;

    // State and layer context
    state_t              r_state;
    logic [PWIDTH-1:0]   r_phase;
    logic [LWIDTH-1:0]   r_written;
    logic [AWIDTH-1:0]   r_base;
    logic [LWIDTH-1:0]   r_out_size;
    logic                r_relu;

    // Registered outputs
    logic                r_mem_we;
    logic [AWIDTH-1:0]   r_mem_addr;
    logic [DWIDTH-1:0]   r_mem_wdata;
    logic                r_busy;
    logic                r_done;
    logic                r_overrun;

    // Next-state / control decode
    state_t              w_state_nxt;
    logic [PWIDTH-1:0]   w_phase_nxt;
    logic                w_start_ok;
    logic                w_overrun_set;
    logic                w_capture;
    logic                w_last_phase;
    logic [LWIDTH-1:0]   w_written_nxt;
    logic [DWIDTH-1:0]   w_wdata;

    // A lane is written only while the layer still has outputs left; this is
    // what masks the unused lanes of the final partial batch.
    assign w_capture     = (r_state == S_STREAM) && (r_written < r_out_size);
    assign w_written_nxt = r_written + LWIDTH'(w_capture);
    assign w_last_phase  = (r_phase == PWIDTH'(CORE));
    assign w_wdata       = (r_relu && i_serial_data[DWIDTH-1]) ? '0 : i_serial_data;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        w_state_nxt   = r_state;
        w_phase_nxt   = r_phase;
        w_start_ok    = 1'b0;
        w_overrun_set = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_start_ok  = 1'b1;
                    // An empty layer has nothing to stream; finish straight away.
                    w_state_nxt = (i_out_size == '0) ? S_FIN : S_ARMED;
                end
            end

            S_ARMED: begin
                if (i_serial_we) begin
                    w_state_nxt = S_STREAM;
                    w_phase_nxt = PWIDTH'(1);
                end
            end

            S_STREAM: begin
                if (w_last_phase) begin
                    // The CORE lane is taken this cycle regardless; completion
                    // wins over a coincident batch-start pulse.
                    if (w_written_nxt == r_out_size) begin
                        w_state_nxt = S_FIN;
                    end else if (i_serial_we) begin
                        w_state_nxt = S_STREAM;
                        w_phase_nxt = PWIDTH'(1);
                    end else begin
                        w_state_nxt = S_ARMED;
                    end
                end else if (i_serial_we) begin
                    // Batch restarted early: the current lane is still taken,
                    // the rest of the old batch is lost.
                    w_phase_nxt   = PWIDTH'(1);
                    w_overrun_set = 1'b1;
                end else begin
                    w_phase_nxt = r_phase + PWIDTH'(1);
                end
            end

            S_FIN: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State, layer context and registered write port
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments only in clocked logic, so every
        // register samples pre-edge values and ordering inside the block is moot.
        if (i_rst) begin
            // NOTE: these are a few flops, not a memory array, so clearing all
            // of them on reset is cheap and gives the quiet outputs the
            // controller expects; an in-flight write is simply dropped.
            r_state     <= S_IDLE;
            r_phase     <= '0;
            r_written   <= '0;
            r_base      <= '0;
            r_out_size  <= '0;
            r_relu      <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;

            if (w_start_ok) begin
                r_base     <= i_base_addr;
                r_out_size <= i_out_size;
                r_relu     <= i_relu_en;
                r_written  <= '0;
                r_busy     <= 1'b1;
                r_overrun  <= 1'b0;
            end else begin
                r_written <= w_written_nxt;
                if (w_overrun_set) begin
                    r_overrun <= 1'b1;
                end
            end

            // One cycle of latency from lane to write. Address uses the
            // pre-increment count and wraps silently at 2^AWIDTH.
            r_mem_we <= w_capture;
            if (w_capture) begin
                r_mem_addr  <= r_base + AWIDTH'(r_written);
                r_mem_wdata <= w_wdata;
            end

            // Done is registered out of FIN so it lands the cycle after the
            // last write; busy drops on the same edge.
            r_done <= (r_state == S_FIN);
            if (r_state == S_FIN) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_overrun   = r_overrun;

endmodule
